// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: opcodes, select encodings, instruction classes and FSM states for multicycle_ctrl.
// S_TRAP exists only when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined.
package rv32_ctrl_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
    typedef enum logic [1:0] {PC_4, PC_IMM, PC_ALU} pc_sel_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_FUNCT, ALU_BR, ALU_PASS_B} alu_op_t;
    typedef enum logic [2:0] {CL_ALU, CL_JAL, CL_JALR, CL_LOAD, CL_STORE, CL_BRANCH, CL_NOP, CL_ILL} cls_t;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
// `illegal` exists only when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_type;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [31:0] retired;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    modport master (
        input  instr, br_taken, mem_ready,
        output mem_req, mem_we, ir_we, pc_we, pc_sel, imm_type, alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, retired
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );
    modport slave (
        output instr, br_taken, mem_ready,
        input  mem_req, mem_we, ir_we, pc_we, pc_sel, imm_type, alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, retired
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode -> static datapath selects and instruction class.
// Unknown opcodes classify as CL_ILL with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN, else as CL_NOP.
module ctrl_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output imm_t       o_imm_type,
    output logic       o_alu_src_a,
    output logic       o_alu_src_b,
    output alu_op_t    o_alu_op,
    output wb_sel_t    o_wb_sel,
    output pc_sel_t    o_jmp_sel,
    output cls_t       o_cls
);
    always_comb begin
        o_imm_type  = IMM_NONE;
        o_alu_src_a = 1'b0;
        o_alu_src_b = 1'b0;
        o_alu_op    = ALU_ADD;
        o_wb_sel    = WB_ALU;
        o_jmp_sel   = PC_4;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        o_cls       = CL_ILL;
`else
        o_cls       = CL_NOP;
`endif
        case (i_opcode)
            OPC_OP:     begin o_cls = CL_ALU; o_alu_op = ALU_FUNCT; end
            OPC_OP_IMM: begin o_cls = CL_ALU; o_alu_op = ALU_FUNCT; o_imm_type = IMM_I; o_alu_src_b = 1'b1; end
            OPC_LUI:    begin o_cls = CL_ALU; o_alu_op = ALU_PASS_B; o_imm_type = IMM_U; o_alu_src_b = 1'b1; end
            OPC_AUIPC:  begin o_cls = CL_ALU; o_imm_type = IMM_U; o_alu_src_a = 1'b1; o_alu_src_b = 1'b1; end
            OPC_JAL:    begin o_cls = CL_JAL; o_imm_type = IMM_J; o_alu_src_a = 1'b1; o_alu_src_b = 1'b1; o_wb_sel = WB_PC4; o_jmp_sel = PC_IMM; end
            OPC_JALR:   begin o_cls = CL_JALR; o_imm_type = IMM_I; o_alu_src_b = 1'b1; o_wb_sel = WB_PC4; o_jmp_sel = PC_ALU; end
            OPC_LOAD:   begin o_cls = CL_LOAD; o_imm_type = IMM_I; o_alu_src_b = 1'b1; o_wb_sel = WB_MEM; end
            OPC_STORE:  begin o_cls = CL_STORE; o_imm_type = IMM_S; o_alu_src_b = 1'b1; end
            OPC_BRANCH: begin o_cls = CL_BRANCH; o_imm_type = IMM_B; o_alu_op = ALU_BR; end
            OPC_FENCE, OPC_SYSTEM: o_cls = CL_NOP;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer producing all datapath controls.
// Optional MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state and raise `illegal`.
module multicycle_ctrl
    import rv32_ctrl_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    state_t      r_state;
    logic [31:0] r_retired;
    imm_t        w_imm_type;
    logic        w_alu_src_a, w_alu_src_b, w_act, w_pc_we, w_unused;
    alu_op_t     w_alu_op;
    wb_sel_t     w_wb_sel;
    pc_sel_t     w_jmp_sel;
    cls_t        w_cls;

    ctrl_decode u_dec (
        .i_opcode    (bus.instr[6:0]),
        .o_imm_type  (w_imm_type),
        .o_alu_src_a (w_alu_src_a),
        .o_alu_src_b (w_alu_src_b),
        .o_alu_op    (w_alu_op),
        .o_wb_sel    (w_wb_sel),
        .o_jmp_sel   (w_jmp_sel),
        .o_cls       (w_cls)
    );

    assign w_unused = ^bus.instr[31:7];
    // The IR still holds the previous instruction during FETCH, so static selects stay 0 until DECODE.
    assign w_act  = r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB};
    assign w_pc_we = (r_state == S_WB)
                  || (r_state == S_EXEC && w_cls inside {CL_BRANCH, CL_NOP})
                  || (r_state == S_MEM && w_cls == CL_STORE && bus.mem_ready);

    assign bus.mem_req   = r_state inside {S_FETCH, S_MEM};
    assign bus.mem_we    = r_state == S_MEM && w_cls == CL_STORE;
    assign bus.ir_we     = r_state == S_FETCH && bus.mem_ready;
    assign bus.pc_we     = w_pc_we;
    assign bus.pc_sel    = (r_state == S_EXEC && w_cls == CL_BRANCH && bus.br_taken) ? PC_IMM
                         : (r_state == S_WB) ? w_jmp_sel : PC_4;
    assign bus.imm_type  = w_act ? w_imm_type : IMM_NONE;
    assign bus.alu_src_a = w_act && w_alu_src_a;
    assign bus.alu_src_b = w_act && w_alu_src_b;
    assign bus.alu_op    = w_act ? w_alu_op : ALU_ADD;
    assign bus.reg_we    = r_state == S_WB;
    assign bus.wb_sel    = w_act ? w_wb_sel : WB_ALU;
    assign bus.retired   = r_retired;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal   = r_state == S_TRAP;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_retired <= '0;
        else if (w_pc_we) r_retired <= r_retired + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  r_state <= bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: r_state <= S_EXEC;
                S_EXEC:   r_state <= w_cls inside {CL_LOAD, CL_STORE} ? S_MEM
                                   : w_cls inside {CL_BRANCH, CL_NOP} ? S_FETCH
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                                   : w_cls == CL_ILL ? S_TRAP
`endif
                                   : S_WB;
                S_MEM:    r_state <= !bus.mem_ready ? S_MEM : w_cls == CL_LOAD ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                S_TRAP:   r_state <= S_TRAP;
`endif
                default:  r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It drives the fetch/decode/execute/memory/writeback flow and produces every datapath control: the immediate-type select for the immediate generator, ALU operand/op selects, register-file write, PC update and the memory request handshake. It sits between the instruction register and the shared datapath. It owns the only FSM in the core.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction register contents; valid from DECODE onward.
- `br_taken` in 1: ALU compare result, sampled in EXEC.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request, held until `mem_ready`.
- `mem_we` out 1: request is a store.
- `ir_we` out 1: load the instruction register.
- `pc_we` out 1: update the PC.
- `pc_sel` out 2: 0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared (JALR).
- `imm_type` out 3: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- `alu_src_a` out 1: 0 = rs1, 1 = PC.
- `alu_src_b` out 1: 0 = rs2, 1 = imm.
- `alu_op` out 2: 0 add, 1 funct-decoded, 2 branch compare, 3 pass-B (LUI).
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: 0 = ALU, 1 = memory data, 2 = PC+4.
- `retired` out 32: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, plus TRAP when the macro is enabled. State is encoded in 3 bits.
- Outputs are combinational from the state and `instr[6:0]`. In IDLE every output is 0.
- IDLE: lasts one cycle after reset, then goes to FETCH.
- FETCH:
  - `mem_req`=1, `mem_we`=0.
  - When `mem_ready`=1: `ir_we`=1 and go to DECODE. Otherwise stay in FETCH.
- DECODE: `imm_type` is valid. Go to EXEC unconditionally.
- EXEC, by opcode:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: go to WB.
  - LOAD, STORE: go to MEM. `alu_src_b`=1 and `alu_op`=0 compute the address.
  - BRANCH: `alu_op`=2, `pc_we`=1, `pc_sel`=`br_taken`?1:0, then go to FETCH.
  - FENCE, SYSTEM: `pc_we`=1, `pc_sel`=0, then go to FETCH (treated as NOP).
  - Other opcodes: see Configuration.
- MEM:
  - `mem_req`=1, `mem_we`=1 for STORE.
  - Wait for `mem_ready`.
  - LOAD then goes to WB.
  - STORE asserts `pc_we` (`pc_sel`=0) in the `mem_ready` cycle, then goes to FETCH.
- WB:
  - `reg_we`=1 and `pc_we`=1, then go to FETCH.
  - JAL: `pc_sel`=1, `wb_sel`=2.
  - JALR: `pc_sel`=2, `wb_sel`=2.
  - LOAD: `wb_sel`=1.
  - Others: `pc_sel`=0, `wb_sel`=0.
- AUIPC and JAL use `alu_src_a`=1.
- `retired` increments by 1 on every `pc_we` cycle and wraps at 2^32 to 0.
- `imm_type`, `alu_*` and `wb_sel` hold their decoded values from DECODE through the last state of the instruction.

## Timing
- With zero wait states (`mem_ready` tied to 1):
  - BRANCH, FENCE: 3 cycles.
  - ALU, U-type, jumps, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle adds 1 cycle in FETCH or MEM.
- `mem_req` is stable while waiting and deasserts the cycle after `mem_ready`. `mem_ready` is ignored outside FETCH/MEM.
- `rst_n` low at any time, including mid-MEM:
  - State goes to IDLE and `retired` to 0 immediately (asynchronously).
  - All outputs are 0 while reset is held.
  - The aborted access is not retried.
- No simultaneous events exist, because each state has a single exit condition.

## Configuration
- `MULTICYCLE_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in EXEC goes to TRAP.
  - TRAP is sticky: no PC/register/memory writes and all outputs 0.
  - Only reset leaves TRAP.
  - Adds output `illegal` out 1, which is 1 in TRAP.
- Macro undefined: an unknown opcode behaves as a NOP (EXEC: `pc_we`=1, `pc_sel`=0, then FETCH). The port and state do not exist.

## Structure
- Package `rv32_ctrl_pkg` holds:
  - Opcode constants (LOAD 0000011, OP-IMM 0010011, AUIPC 0010111, STORE 0100011, OP 0110011, LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111, FENCE 0001111, SYSTEM 1110011).
  - The `imm_type`, `pc_sel`, `wb_sel` and `alu_op` encodings.
  - The state enum.
- Sub-module `ctrl_decode`: combinational decode from opcode to the static selects (`imm_type`, `alu_src_*`, `alu_op`, `wb_sel`) and an instruction class. The FSM instantiates it.

## Test plan
- ADDI x1,x0,5 (0x00500093), `mem_ready`=1: 4 cycles. `imm_type`=1, `alu_src_b`=1, `reg_we`=1 in cycle 4, `retired` 0→1.
- LW with 2 wait states in MEM: `mem_req` high for 3 MEM cycles, then WB with `wb_sel`=1. Total 7 cycles.
- BEQ with `br_taken`=1, then with `br_taken`=0: `pc_sel`=1, then 0. `imm_type`=3, 3 cycles each, `reg_we` never asserted.
- JALR: WB shows `pc_sel`=2, `wb_sel`=2, `reg_we`=1. JAL: `imm_type`=5, `pc_sel`=1.
- `rst_n` pulsed low mid-MEM of SW: `mem_req` drops immediately and `retired`=0. IDLE for 1 cycle, then FETCH.
- Opcode 0x7F: with the macro, `illegal`=1 and no further `mem_req`. Without it, 3-cycle NOP and `retired` increments.
